// File: rtl/fp_div_seq.sv
// fp_div_seq: iterative floating-point divider with a valid/ready handshake.
// The quotient mantissa comes from restoring division, one bit per cycle.
// Results are rounded to nearest even. Special operands (zero, inf, NaN)
// bypass the divider. Subnormal inputs are flushed to zero.
// Optional macro FP_DIV_RADIX4_EN retires two quotient bits per cycle.
// Results are identical in both builds.
//
// Handshake: an operand pair is taken on a rising edge where in_valid and
// in_ready are both high. A result is handed off on a rising edge where
// out_valid and out_ready are both high. quotient and all flags stay stable
// while out_valid is high and out_ready is low. in_ready is high only in
// IDLE. After a handoff, in_ready returns one cycle later.
module fp_div_seq #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 7,
   localparam int W = 1 + EXP_W + MAN_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] opA,
   input  logic [W-1:0] opB,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] quotient,
   output logic         overflow,
   output logic         underflow,
   output logic         inexact,
   output logic         div_by_zero,
   output logic         invalid,
   output logic [1:0]   dbg_state
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_DIVIDE = 2'd1;
   localparam logic [1:0] S_NORM   = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   localparam int QW = MAN_W + 3;            // quotient bits produced
   localparam int RW = MAN_W + 2;            // partial remainder width
   localparam int CW = $clog2(MAN_W + 4);    // step counter width
   localparam int XW = EXP_W + 2;            // signed working exponent width
   localparam logic [CW-1:0] STEPS  = CW'(QW);
   localparam logic [XW-1:0] BIAS_X = XW'((1 << (EXP_W - 1)) - 1);
   localparam logic [XW-1:0] EMAX_X = XW'((1 << EXP_W) - 1);

   logic [1:0]       state;
   logic             sgn;
   logic [EXP_W-1:0] ea, eb;
   logic [MAN_W:0]   mb;
   logic [RW-1:0]    rem;
   logic [QW-1:0]    q;
   logic [CW-1:0]    cnt;
   logic             is_spec, hold;
   logic [W-1:0]     spec_q;
   logic             spec_inv, spec_dbz;

   assign in_ready  = (state == S_IDLE) && !reset;
   assign dbg_state = state;

   // One restoring step: returns {quotient bit, next remainder}.
   function automatic logic [RW:0] div_step(input logic [RW-1:0] r, input logic [MAN_W:0] d);
      logic [RW:0]   diff;
      logic [RW-1:0] t;
      diff = {1'b0, r} - {2'b00, d};
      t    = diff[RW-1:0];
      if (!diff[RW]) div_step = {1'b1, t << 1};
      else           div_step = {1'b0, r << 1};
   endfunction

   // Operand classification for the accept cycle.
   logic [EXP_W-1:0] a_exp, b_exp;
   logic [MAN_W-1:0] a_frac, b_frac;
   logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, acc_spec, acc_sgn;
   logic [W-1:0]     acc_q;
   logic             acc_inv, acc_dbz;

   // Decide special-operand results straight from the incoming operands.
   always_comb begin
      a_exp    = opA[W-2:MAN_W];
      b_exp    = opB[W-2:MAN_W];
      a_frac   = opA[MAN_W-1:0];
      b_frac   = opB[MAN_W-1:0];
      a_zero   = (a_exp == '0);
      b_zero   = (b_exp == '0);
      a_inf    = (&a_exp) && (a_frac == '0);
      b_inf    = (&b_exp) && (b_frac == '0);
      a_nan    = (&a_exp) && (a_frac != '0);
      b_nan    = (&b_exp) && (b_frac != '0);
      acc_sgn  = opA[W-1] ^ opB[W-1];
      acc_spec = a_zero | b_zero | a_inf | b_inf | a_nan | b_nan;
      acc_inv  = 1'b0;
      acc_dbz  = 1'b0;
      acc_q    = {acc_sgn, {(W-1){1'b0}}};
      if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
         acc_q   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
         acc_inv = 1'b1;
      end else if (a_inf) begin
         acc_q = {acc_sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (b_zero) begin
         acc_q   = {acc_sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         acc_dbz = 1'b1;
      end
   end

   // Next quotient/remainder/counter for the DIVIDE state.
   logic [RW:0]   st1, st2;
   logic [QW-1:0] q_n;
   logic [RW-1:0] rem_n;
   logic [CW-1:0] cnt_n;

   // Chain one or two restoring steps per cycle.
   always_comb begin
      st1   = div_step(rem, mb);
      st2   = div_step(st1[RW-1:0], mb);
      q_n   = {q[QW-2:0], st1[RW]};
      rem_n = st1[RW-1:0];
      cnt_n = cnt - CW'(1);
`ifdef FP_DIV_RADIX4_EN
      if (cnt >= CW'(2)) begin
         q_n   = {q[QW-3:0], st1[RW], st2[RW]};
         rem_n = st2[RW-1:0];
         cnt_n = cnt - CW'(2);
      end
`endif
   end

   // Normalise, round to nearest even and range-check the exponent.
   logic           msb, g, s, inc, carry, n_ovf, n_unf, n_inx;
   logic [MAN_W:0] mant_pre;
   logic [MAN_W-1:0] frac_r;
   logic [XW-1:0]  e;
   logic [W-1:0]   n_q;

   // Build the rounded result from the raw quotient and remainder.
   always_comb begin
      msb      = q[QW-1];
      mant_pre = msb ? q[QW-1:2] : q[QW-2:1];
      g        = msb ? q[1] : q[0];
      s        = (msb & q[0]) | (rem != '0);
      inc      = g & (s | mant_pre[0]);
      carry    = (&mant_pre) & inc;
      // On carry-out the fraction wraps to zero and the mantissa reads 1.000.
      frac_r   = mant_pre[MAN_W-1:0] + {{(MAN_W-1){1'b0}}, inc};
      e        = {2'b00, ea} - {2'b00, eb} + BIAS_X
                 - {{(XW-1){1'b0}}, !msb} + {{(XW-1){1'b0}}, carry};
      n_ovf    = !e[XW-1] && (e >= EMAX_X);
      n_unf    = e[XW-1] || (e == '0);
      n_inx    = g | s;
      n_q      = {sgn, e[EXP_W-1:0], frac_r};
      if (n_ovf) begin
         n_q   = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         n_inx = 1'b1;
      end else if (n_unf) begin
         n_q   = {sgn, {(W-1){1'b0}}};
         n_inx = 1'b1;
      end
   end

   // Control FSM, divider datapath and result registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         sgn         <= 1'b0;
         ea          <= '0;
         eb          <= '0;
         mb          <= '0;
         rem         <= '0;
         q           <= '0;
         cnt         <= '0;
         is_spec     <= 1'b0;
         hold        <= 1'b0;
         spec_q      <= '0;
         spec_inv    <= 1'b0;
         spec_dbz    <= 1'b0;
         out_valid   <= 1'b0;
         quotient    <= '0;
         overflow    <= 1'b0;
         underflow   <= 1'b0;
         inexact     <= 1'b0;
         div_by_zero <= 1'b0;
         invalid     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  sgn      <= acc_sgn;
                  is_spec  <= acc_spec;
                  spec_q   <= acc_q;
                  spec_inv <= acc_inv;
                  spec_dbz <= acc_dbz;
                  if (acc_spec) begin
                     // Special results wait one extra cycle in NORM.
                     hold  <= 1'b1;
                     state <= S_NORM;
                  end else begin
                     ea    <= a_exp;
                     eb    <= b_exp;
                     mb    <= {1'b1, b_frac};
                     rem   <= {1'b0, 1'b1, a_frac};
                     q     <= '0;
                     cnt   <= STEPS;
                     state <= S_DIVIDE;
                  end
               end
            end
            S_DIVIDE: begin
               q   <= q_n;
               rem <= rem_n;
               cnt <= cnt_n;
               if (cnt_n == '0) state <= S_NORM;
            end
            S_NORM: begin
               if (hold) begin
                  hold <= 1'b0;
               end else begin
                  out_valid <= 1'b1;
                  state     <= S_DONE;
                  if (is_spec) begin
                     quotient    <= spec_q;
                     overflow    <= 1'b0;
                     underflow   <= 1'b0;
                     inexact     <= 1'b0;
                     div_by_zero <= spec_dbz;
                     invalid     <= spec_inv;
                  end else begin
                     quotient    <= n_q;
                     overflow    <= n_ovf;
                     underflow   <= n_unf & !n_ovf;
                     inexact     <= n_inx;
                     div_by_zero <= 1'b0;
                     invalid     <= 1'b0;
                  end
               end
            end
            default: begin
               if (out_ready) begin
                  out_valid   <= 1'b0;
                  quotient    <= '0;
                  overflow    <= 1'b0;
                  underflow   <= 1'b0;
                  inexact     <= 1'b0;
                  div_by_zero <= 1'b0;
                  invalid     <= 1'b0;
                  state       <= S_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed self-checking bench for fp_div_seq at the default bfloat16 format.
module tb_fp_div_seq;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] opA, opB;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] quotient;
   logic        overflow, underflow, inexact, div_by_zero, invalid;
   logic [1:0]  dbg_state;

   int checks   = 0;
   int failures = 0;

`ifdef FP_DIV_RADIX4_EN
   localparam int NORM_LAT = 6;
`else
   localparam int NORM_LAT = 11;
`endif
   localparam int SPEC_LAT = 2;

   // flag vector order: {overflow, underflow, inexact, div_by_zero, invalid}
   localparam logic [4:0] F_NONE = 5'b00000;
   localparam logic [4:0] F_OVF  = 5'b10100;
   localparam logic [4:0] F_UNF  = 5'b01100;
   localparam logic [4:0] F_INX  = 5'b00100;
   localparam logic [4:0] F_DBZ  = 5'b00010;
   localparam logic [4:0] F_INV  = 5'b00001;

   fp_div_seq dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .opA(opA), .opB(opB), .out_valid(out_valid), .out_ready(out_ready),
      .quotient(quotient), .overflow(overflow), .underflow(underflow),
      .inexact(inexact), .div_by_zero(div_by_zero), .invalid(invalid),
      .dbg_state(dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [4:0] flags_now();
      return {overflow, underflow, inexact, div_by_zero, invalid};
   endfunction

   // Driver: launch one operation, measure latency, capture result, hand off.
   task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] q, output logic [4:0] f, output int lat);
      int guard;
      guard = 0;
      while (!in_ready && guard < 50) begin
         @(posedge clk); #1; guard++;
      end
      @(negedge clk);
      opA = a; opB = b; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1; lat++;
      end
      q = quotient;
      f = flags_now();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
      checks++;
      if ({out_valid, quotient, flags_now()} !== 22'd0) begin
         failures++; $display("FAIL reset_outputs got=%h exp=0", {out_valid, quotient, flags_now()});
      end
      @(negedge clk); reset = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_normal();
      logic [15:0] va[5] = '{16'h3F80, 16'h3F80, 16'h40C0, 16'h4000, 16'hBF80};
      logic [15:0] vb[5] = '{16'h3F80, 16'h4040, 16'hC000, 16'h4000, 16'h3F00};
      logic [15:0] vq[5] = '{16'h3F80, 16'h3EAB, 16'hC040, 16'h3F80, 16'hC000};
      logic [4:0]  vf[5] = '{F_NONE, F_INX, F_NONE, F_NONE, F_NONE};
      logic [15:0] q;
      logic [4:0]  f;
      int lat;
      for (int i = 0; i < 5; i++) begin
         run_op(va[i], vb[i], q, f, lat);
         checks++;
         if (q !== vq[i]) begin failures++; $display("FAIL normal_q[%0d] got=%h exp=%h", i, q, vq[i]); end
         checks++;
         if (f !== vf[i]) begin failures++; $display("FAIL normal_flags[%0d] got=%b exp=%b", i, f, vf[i]); end
         checks++;
         if (lat !== NORM_LAT) begin failures++; $display("FAIL normal_latency[%0d] got=%0d exp=%0d", i, lat, NORM_LAT); end
      end
   endtask

   task automatic test_range();
      logic [15:0] va[2] = '{16'h7F00, 16'h0080};
      logic [15:0] vb[2] = '{16'h3E80, 16'h4000};
      logic [15:0] vq[2] = '{16'h7F80, 16'h0000};
      logic [4:0]  vf[2] = '{F_OVF, F_UNF};
      logic [15:0] q;
      logic [4:0]  f;
      int lat;
      for (int i = 0; i < 2; i++) begin
         run_op(va[i], vb[i], q, f, lat);
         checks++;
         if (q !== vq[i]) begin failures++; $display("FAIL range_q[%0d] got=%h exp=%h", i, q, vq[i]); end
         checks++;
         if (f !== vf[i]) begin failures++; $display("FAIL range_flags[%0d] got=%b exp=%b", i, f, vf[i]); end
      end
   endtask

   task automatic test_special();
      logic [15:0] va[7] = '{16'h3F80, 16'h0000, 16'h7F80, 16'h3F80, 16'h7F80, 16'h0000, 16'h7FC1};
      logic [15:0] vb[7] = '{16'h0000, 16'h0000, 16'h7F80, 16'h7F80, 16'hC000, 16'hBF80, 16'h3F80};
      logic [15:0] vq[7] = '{16'h7F80, 16'h7FC0, 16'h7FC0, 16'h0000, 16'hFF80, 16'h8000, 16'h7FC0};
      logic [4:0]  vf[7] = '{F_DBZ, F_INV, F_INV, F_NONE, F_NONE, F_NONE, F_INV};
      logic [15:0] q;
      logic [4:0]  f;
      int lat;
      for (int i = 0; i < 7; i++) begin
         run_op(va[i], vb[i], q, f, lat);
         checks++;
         if (q !== vq[i]) begin failures++; $display("FAIL special_q[%0d] got=%h exp=%h", i, q, vq[i]); end
         checks++;
         if (f !== vf[i]) begin failures++; $display("FAIL special_flags[%0d] got=%b exp=%b", i, f, vf[i]); end
         checks++;
         if (lat !== SPEC_LAT) begin failures++; $display("FAIL special_latency[%0d] got=%0d exp=%0d", i, lat, SPEC_LAT); end
      end
   endtask

   task automatic test_backpressure();
      int lat;
      @(negedge clk);
      opA = 16'h3F80; opB = 16'h4040; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
      checks++;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_first_valid got=%b exp=1", out_valid); end
      opA = 16'h40C0; opB = 16'hC000; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++;
         if ({out_valid, in_ready, quotient, flags_now()} !== {1'b1, 1'b0, 16'h3EAB, F_INX}) begin
            failures++;
            $display("FAIL bp_hold[%0d] got valid=%b ready=%b q=%h f=%b exp valid=1 ready=0 q=3eab f=%b",
                     i, out_valid, in_ready, quotient, flags_now(), F_INX);
         end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++;
      if ({out_valid, in_ready, quotient, flags_now()} !== {1'b0, 1'b1, 16'h0000, F_NONE}) begin
         failures++;
         $display("FAIL bp_handoff got valid=%b ready=%b q=%h f=%b exp valid=0 ready=1 q=0 f=0",
                  out_valid, in_ready, quotient, flags_now());
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
      checks++;
      if (quotient !== 16'hC040) begin failures++; $display("FAIL bp_second_q got=%h exp=c040", quotient); end
      checks++;
      if (lat !== NORM_LAT) begin failures++; $display("FAIL bp_second_latency got=%0d exp=%0d", lat, NORM_LAT); end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [15:0] q;
      logic [4:0]  f;
      int lat;
      int stale;
      @(negedge clk);
      opA = 16'h3F80; opB = 16'h4040; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (dbg_state !== 2'd1) begin failures++; $display("FAIL mid_in_divide got=%0d exp=1", dbg_state); end
      reset = 1'b1;
      #1;
      checks++;
      if ({out_valid, quotient, flags_now(), dbg_state} !== 24'd0) begin
         failures++; $display("FAIL mid_reset_clear got=%h exp=0", {out_valid, quotient, flags_now(), dbg_state});
      end
      repeat (2) @(posedge clk);
      @(negedge clk); reset = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_release_in_ready got=%b exp=1", in_ready); end
      stale = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         if (out_valid) stale++;
      end
      checks++;
      if (stale !== 0) begin failures++; $display("FAIL mid_no_stale got=%0d exp=0", stale); end
      run_op(16'h4000, 16'h4000, q, f, lat);
      checks++;
      if ({q, f} !== {16'h3F80, F_NONE}) begin
         failures++; $display("FAIL mid_new_op got q=%h f=%b exp q=3f80 f=0", q, f);
      end
   endtask

   initial begin
      in_valid  = 1'b0;
      out_ready = 1'b0;
      opA       = '0;
      opB       = '0;
      test_reset();
      test_normal();
      test_range();
      test_special();
      test_backpressure();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
